switch_control: RTL

SWITCH_CONTROL -- requirements
Module: switch_control

---
 rtl/switch_control.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/switch_control.sv
// -----------------------------------------------------------------------------
// switch_control
// Crossbar control for an NPORT-port XY-routed wormhole router. A single
// arbiter walks the requesting inputs round-robin, XY-routes the winner's
// header flit and, if the chosen output is free, opens an input->output
// connection. Open connections move flits whenever the input FIFO is
// non-empty and the downstream side has credit; the connection closes on the
// last flit of the packet (header, size, then size payload flits).
// WIDTH must be even (X in the upper half, Y in the lower half of a flit).
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   addr       this router's address {X, Y}
//   req        input FIFO i non-empty
//   head_flat  head flit of input FIFO i at [i*WIDTH +: WIDTH]
//   credit     downstream of output o accepts a flit this cycle
//   pull       pop input FIFO i this cycle (combinational)
//   tx         output o transmits a flit this cycle (combinational)
//   sel_flat   input driving output o at [o*3 +: 3], valid while out_busy[o]
//   out_busy   output o is held by a connection
// -----------------------------------------------------------------------------
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif

module switch_control #(
  parameter int unsigned WIDTH = `TAM_FLIT,
  parameter int unsigned NPORT = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       addr,
  input  logic [NPORT-1:0]       req,
  input  logic [NPORT*WIDTH-1:0] head_flat,
  input  logic [NPORT-1:0]       credit,
  output logic [NPORT-1:0]       pull,
  output logic [NPORT-1:0]       tx,
  output logic [NPORT*3-1:0]     sel_flat,
  output logic [NPORT-1:0]       out_busy
);

  localparam int unsigned HW = WIDTH / 2;

  localparam logic [2:0] P_EAST  = 3'd0;
  localparam logic [2:0] P_WEST  = 3'd1;
  localparam logic [2:0] P_NORTH = 3'd2;
  localparam logic [2:0] P_SOUTH = 3'd3;
  localparam logic [2:0] P_LOCAL = 3'd4;

  typedef enum logic {S_IDLE, S_ROUTE} state_t;
  typedef enum logic [1:0] {PH_HEADER, PH_SIZE, PH_PAYLOAD} phase_t;

  state_t           r_state;
  logic [2:0]       r_rr_ptr;
  logic [2:0]       r_cand;
  logic [NPORT-1:0] r_conn;
  logic [2:0]       r_conn_out [NPORT];
  phase_t           r_phase    [NPORT];
  logic [WIDTH-1:0] r_left     [NPORT];
  logic [NPORT-1:0] r_out_busy;
  logic [2:0]       r_sel      [NPORT];

  logic [WIDTH-1:0] w_head [NPORT];
  logic [NPORT-1:0] w_fire;
  logic             w_cand_found;
  logic [2:0]       w_cand;
  logic [2:0]       w_rr_idx;
  logic [WIDTH-1:0] w_cand_head;
  logic [2:0]       w_route;

  // Unpack head flits
  always_comb begin
    for (int i = 0; i < int'(NPORT); i++) begin
      w_head[i] = head_flat[i*WIDTH +: WIDTH];
    end
  end

  // A connected input moves a flit when it has data and its output has credit
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      w_fire[i] = r_conn[i] & req[i] & credit[r_conn_out[i]];
    end
  end

  assign pull     = w_fire;
  assign out_busy = r_out_busy;

  // tx mirrors the fire of whichever input holds the output
  always_comb begin
    tx       = '0;
    sel_flat = '0;
    for (int o = 0; o < int'(NPORT); o++) begin
      tx[o]              = r_out_busy[o] & w_fire[r_sel[o]];
      sel_flat[o*3 +: 3] = r_sel[o];
    end
  end

  // Round-robin search for an unconnected requester, starting after r_rr_ptr
  always_comb begin
    w_cand_found = 1'b0;
    w_cand       = r_rr_ptr;
    w_rr_idx     = '0;
    for (int unsigned k = 1; k <= NPORT; k++) begin
      w_rr_idx = 3'((32'(r_rr_ptr) + k) % NPORT);
      if (!w_cand_found && req[w_rr_idx] && !r_conn[w_rr_idx]) begin
        w_cand_found = 1'b1;
        w_cand       = w_rr_idx;
      end
    end
  end

  // XY route of the latched candidate's header (X first, unsigned compares)
  always_comb begin
    w_cand_head = w_head[r_cand];
    if (w_cand_head[WIDTH-1:HW] > addr[WIDTH-1:HW]) begin
      w_route = P_EAST;
    end else if (w_cand_head[WIDTH-1:HW] < addr[WIDTH-1:HW]) begin
      w_route = P_WEST;
    end else if (w_cand_head[HW-1:0] > addr[HW-1:0]) begin
      w_route = P_NORTH;
    end else if (w_cand_head[HW-1:0] < addr[HW-1:0]) begin
      w_route = P_SOUTH;
    end else begin
      w_route = P_LOCAL;
    end
  end

  // Arbiter FSM plus per-connection packet tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 3'(NPORT - 1);
      r_cand     <= '0;
      r_conn     <= '0;
      r_out_busy <= '0;
      for (int i = 0; i < int'(NPORT); i++) begin
        r_conn_out[i] <= '0;
        r_phase[i]    <= PH_HEADER;
        r_left[i]     <= '0;
        r_sel[i]      <= '0;
      end
    end else begin
      // Packet progress; the last flit releases the connection at this edge
      for (int i = 0; i < int'(NPORT); i++) begin
        if (w_fire[i]) begin
          case (r_phase[i])
            PH_HEADER: r_phase[i] <= PH_SIZE;
            PH_SIZE: begin
              if (w_head[i] == '0) begin
                r_conn[i]                <= 1'b0;
                r_out_busy[r_conn_out[i]] <= 1'b0;
                r_phase[i]               <= PH_HEADER;
                r_left[i]                <= '0;
              end else begin
                r_left[i]  <= w_head[i];
                r_phase[i] <= PH_PAYLOAD;
              end
            end
            PH_PAYLOAD: begin
              if (r_left[i] == WIDTH'(1)) begin
                r_conn[i]                <= 1'b0;
                r_out_busy[r_conn_out[i]] <= 1'b0;
                r_phase[i]               <= PH_HEADER;
                r_left[i]                <= '0;
              end else begin
                r_left[i] <= r_left[i] - WIDTH'(1);
              end
            end
            default: r_phase[i] <= PH_HEADER;
          endcase
        end
      end

      // A grant only targets an output whose registered busy is clear, so it
      // can never collide with a release issued in the loop above
      case (r_state)
        S_IDLE: begin
          if (w_cand_found) begin
            r_cand  <= w_cand;
            r_state <= S_ROUTE;
          end
        end
        S_ROUTE: begin
          if (!r_out_busy[w_route]) begin
            r_conn[r_cand]      <= 1'b1;
            r_conn_out[r_cand]  <= w_route;
            r_phase[r_cand]     <= PH_HEADER;
            r_out_busy[w_route] <= 1'b1;
            r_sel[w_route]      <= r_cand;
          end
          r_rr_ptr <= r_cand;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
